// File: rtl/dtree_pkg.sv
// ============================================================================
// dtree_pkg : shared defaults and sequencer states for the classifier feeder
// rev 1.0
// ============================================================================
`default_nettype none

package dtree_pkg;

   localparam int FEATURES_DEF = 3;
   localparam int IN_WIDTH_DEF = 10;
   localparam int DEPTH_DEF    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/dtree_feeder_fifo.sv
// ============================================================================
// dtree_feeder_fifo : synchronous FIFO with full/empty/occupancy and look-ahead
// rev 1.0
// ============================================================================
`default_nettype none

module dtree_feeder_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic [WIDTH-1:0]       rdata_next_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [AW-1:0]    w_rd_ptr_inc;
   logic             w_push;
   logic             w_pop;

   assign full_o       = (count_q == CW'(DEPTH));
   assign empty_o      = (count_q == '0);
   assign w_push       = push_i && !full_o;
   assign w_pop        = pop_i && !empty_o;
   assign w_rd_ptr_inc = rd_ptr_q + AW'(1);
   assign rdata_o      = mem_q[rd_ptr_q];
   // Second entry lets the consumer reload its output register on a pop edge.
   assign rdata_next_o = mem_q[w_rd_ptr_inc];
   assign count_o      = count_q;

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= w_rd_ptr_inc;
         end
         case ({w_push, w_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/dtree_feeder.sv
// ============================================================================
// dtree_feeder : buffers ADC samples and streams whole frames to a classifier.
// rev 1.0 -- overflow/frame_count live only with DTREE_FEEDER_STATS_EN defined
// ============================================================================
`default_nettype none

module dtree_feeder
   import dtree_pkg::*;
#(
   parameter int FEATURES = FEATURES_DEF,
   parameter int IN_WIDTH = IN_WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                adc_valid,
   input  logic [IN_WIDTH-1:0] adc_sample,
   output logic                adc_ready,
   input  logic                dt_ready,
   output logic                dt_valid,
   output logic [IN_WIDTH-1:0] dt_sample,
   output logic                overflow,
   output logic [15:0]         frame_count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int BW = (FEATURES > 1) ? $clog2(FEATURES) : 1;

   state_t              state_q;
   logic [BW-1:0]       beat_q;
   logic                frame_ready_q;
   logic                dt_valid_q;
   logic [IN_WIDTH-1:0] dt_sample_q;

   logic                w_full;
   logic                w_empty;
   logic [CW-1:0]       w_count;
   logic [IN_WIDTH-1:0] w_head;
   logic [IN_WIDTH-1:0] w_head_next;
   logic                w_push;
   logic                w_pop;
   logic                w_last_beat;

   assign adc_ready   = !w_full;
   assign w_push      = adc_valid && !w_full;
   assign w_pop       = (state_q == SEND) && dt_ready;
   assign w_last_beat = (beat_q == BW'(FEATURES - 1));

   dtree_feeder_fifo #(
      .WIDTH (IN_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_i       (w_push),
      .wdata_i      (adc_sample),
      .pop_i        (w_pop),
      .rdata_o      (w_head),
      .rdata_next_o (w_head_next),
      .full_o       (w_full),
      .empty_o      (w_empty),
      .count_o      (w_count)
   );

   // A frame only starts once all of it is queued, so SEND never underruns.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         beat_q        <= '0;
         frame_ready_q <= 1'b0;
         dt_valid_q    <= 1'b0;
         dt_sample_q   <= '0;
      end else begin
         frame_ready_q <= (w_count >= CW'(FEATURES)) && !w_empty;
         case (state_q)
            IDLE: begin
               if (frame_ready_q && dt_ready) begin
                  state_q     <= SEND;
                  beat_q      <= '0;
                  dt_valid_q  <= 1'b1;
                  dt_sample_q <= w_head;
               end
            end
            SEND: begin
               if (dt_ready) begin
                  if (w_last_beat) begin
                     state_q    <= GAP;
                     beat_q     <= '0;
                     dt_valid_q <= 1'b0;
                  end else begin
                     beat_q      <= beat_q + BW'(1);
                     dt_sample_q <= w_head_next;
                  end
               end
            end
            GAP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q    <= IDLE;
               dt_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign dt_valid  = dt_valid_q;
   assign dt_sample = dt_sample_q;

`ifdef DTREE_FEEDER_STATS_EN
   logic        overflow_q;
   logic [15:0] frame_count_q;
   logic [15:0] frame_count_d;

   assign frame_count_d = frame_count_q + 16'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q    <= 1'b0;
         frame_count_q <= '0;
      end else begin
         if (adc_valid && w_full) begin
            overflow_q <= 1'b1;
         end
         if ((state_q == SEND) && dt_ready && w_last_beat) begin
            frame_count_q <= frame_count_d;
         end
      end
   end

   assign overflow    = overflow_q;
   assign frame_count = frame_count_q;
`else
   assign overflow    = 1'b0;
   assign frame_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dtree_feeder.sv
// ============================================================================
// tb_dtree_feeder : directed stimulus, queue-based reference, per-cycle checks
// rev 1.0
// ============================================================================
`default_nettype none

module tb_dtree_feeder;

   localparam int FEATURES = 3;
   localparam int IN_WIDTH = 10;
   localparam int DEPTH    = 8;
`ifdef DTREE_FEEDER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset;
   logic                adc_valid;
   logic [IN_WIDTH-1:0] adc_sample;
   logic                adc_ready;
   logic                dt_ready;
   logic                dt_valid;
   logic [IN_WIDTH-1:0] dt_sample;
   logic                overflow;
   logic [15:0]         frame_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dtree_feeder #(
      .FEATURES (FEATURES),
      .IN_WIDTH (IN_WIDTH),
      .DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .adc_valid   (adc_valid),
      .adc_sample  (adc_sample),
      .adc_ready   (adc_ready),
      .dt_ready    (dt_ready),
      .dt_valid    (dt_valid),
      .dt_sample   (dt_sample),
      .overflow    (overflow),
      .frame_count (frame_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: FIFO contents as a queue; a frame may start on an edge once
   // the occupancy seen two edges earlier covers a whole frame, the line has
   // been idle since the gap cycle, and the classifier is ready.
   int unsigned mq[$];
   bit          m_live = 1'b0;
   bit          m_valid;
   int unsigned m_sample;
   int          m_sent;
   int          m_idle;
   int          m_occ2;
   bit          m_ovf;
   int          m_frames;

   always @(posedge clk) begin
      bit xfer;
      bit start;
      int pre;
      if (reset) begin
         mq.delete();
         m_live   = 1'b1;
         m_valid  = 1'b0;
         m_sample = 0;
         m_sent   = 0;
         m_idle   = 1;
         m_occ2   = 0;
         m_ovf    = 1'b0;
         m_frames = 0;
      end else if (m_live) begin
         pre   = mq.size();
         xfer  = m_valid && dt_ready;
         start = !m_valid && (m_idle >= 1) && (m_occ2 >= FEATURES) && dt_ready;
         if (m_idle < 1) m_idle = 1;
         if (xfer) begin
            void'(mq.pop_front());
            m_sent++;
         end
         if (adc_valid) begin
            if (pre < DEPTH) mq.push_back(int'(adc_sample));
            else m_ovf = 1'b1;
         end
         if (xfer) begin
            if (m_sent == FEATURES) begin
               m_valid  = 1'b0;
               m_sent   = 0;
               m_frames = (m_frames + 1) % 65536;
               m_idle   = 0;
            end else begin
               m_sample = mq[0];
            end
         end else if (start) begin
            m_valid  = 1'b1;
            m_sample = mq[0];
            m_sent   = 0;
         end
         m_occ2 = pre;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("dt_valid", {31'd0, dt_valid}, {31'd0, m_valid});
         chk("adc_ready", {31'd0, adc_ready}, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
         chk("overflow", {31'd0, overflow}, {31'd0, STATS && m_ovf});
         chk("frame_count", {16'd0, frame_count}, STATS ? m_frames : 0);
         if (m_valid) chk("dt_sample", {22'd0, dt_sample}, m_sample);
      end
   end

   // Record accepted beats with the edge index they were taken on.
   int unsigned rx[$];
   int          rx_cyc[$];
   int          cyc_n = 0;

   always @(posedge clk) begin
      cyc_n++;
      if (!reset && dt_valid && dt_ready) begin
         rx.push_back(int'(dt_sample));
         rx_cyc.push_back(cyc_n);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push(input int v);
      adc_valid  = 1'b1;
      adc_sample = IN_WIDTH'(v);
      step(1);
      adc_valid  = 1'b0;
   endtask

   task automatic wait_rx(input string name, input int n, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (rx.size() >= n) break;
         step(1);
      end
      chk(name, rx.size(), n);
   endtask

   int e1[3] = '{10, 20, 30};
   int e2[6] = '{1, 2, 3, 4, 5, 6};
   int e3[3] = '{7, 8, 9};
   int e4[9] = '{101, 102, 103, 104, 105, 106, 107, 108, 110};

   initial begin
      int e0;
      reset      = 1'b1;
      adc_valid  = 1'b0;
      adc_sample = '0;
      dt_ready   = 1'b0;
      step(3);
      reset = 1'b0;
      step(1);
      chk("rst_adc_ready", {31'd0, adc_ready}, 1);
      chk("rst_dt_valid", {31'd0, dt_valid}, 0);
      chk("rst_dt_sample", {22'd0, dt_sample}, 0);
      chk("rst_frame_count", {16'd0, frame_count}, 0);

      // One frame, latency and back-to-back beats.
      dt_ready = 1'b1;
      rx.delete(); rx_cyc.delete();
      push(10); push(20); push(30);
      e0 = cyc_n;
      wait_rx("t1_beats", 3, 20);
      for (int i = 0; i < 3; i++) chk("t1_data", rx[i], e1[i]);
      chk("t1_first_edge", rx_cyc[0], e0 + 3);
      chk("t1_last_edge", rx_cyc[2], e0 + 5);
      step(1);
      chk("t1_gap_valid", {31'd0, dt_valid}, 0);
      step(3);
      chk("t1_frames", {16'd0, frame_count}, STATS ? 1 : 0);

      // Partial frame waits for completion.
      rx.delete(); rx_cyc.delete();
      for (int v = 1; v <= 5; v++) push(v);
      step(10);
      chk("t2_first_frame", rx.size(), 3);
      push(6);
      wait_rx("t2_second_frame", 6, 20);
      for (int i = 0; i < 6; i++) chk("t2_data", rx[i], e2[i]);
      step(4);

      // Stall on beat 2.
      rx.delete(); rx_cyc.delete();
      push(7); push(8); push(9);
      wait_rx("t3_beat1", 1, 20);
      dt_ready = 1'b0;
      step(3);
      chk("t3_hold_valid", {31'd0, dt_valid}, 1);
      chk("t3_hold_sample", {22'd0, dt_sample}, 8);
      chk("t3_no_xfer", rx.size(), 1);
      dt_ready = 1'b1;
      wait_rx("t3_frame", 3, 20);
      for (int i = 0; i < 3; i++) chk("t3_data", rx[i], e3[i]);
      step(4);

      // Fill past capacity with the classifier stalled.
      rx.delete(); rx_cyc.delete();
      dt_ready = 1'b0;
      for (int v = 101; v <= 108; v++) push(v);
      chk("t4_full_ready", {31'd0, adc_ready}, 0);
      push(109);
      chk("t4_overflow", {31'd0, overflow}, {31'd0, STATS});
      dt_ready = 1'b1;
      wait_rx("t4_two_frames", 6, 40);
      step(6);
      chk("t4_held", rx.size(), 6);
      push(110);
      wait_rx("t4_three_frames", 9, 40);
      for (int i = 0; i < 9; i++) chk("t4_data", rx[i], e4[i]);
      step(4);

      // Reset during a frame.
      rx.delete(); rx_cyc.delete();
      push(1); push(2); push(3);
      wait_rx("t5_beat1", 1, 20);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("t5_valid", {31'd0, dt_valid}, 0);
      chk("t5_adc_ready", {31'd0, adc_ready}, 1);
      chk("t5_frames", {16'd0, frame_count}, 0);
      push(4); push(5);
      step(10);
      chk("t5_flushed", rx.size(), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/dtree_feeder.md
DTREE_FEEDER -- requirements
Module: dtree_feeder

Interface
REQ-001 SHALL have parameter FEATURES, default 3: samples per classification frame.
REQ-002 SHALL have parameter IN_WIDTH, default 10: sample width in bits.
REQ-003 SHALL have parameter DEPTH, default 8: FIFO entries, power of two, DEPTH >= FEATURES.
REQ-004 SHALL have port clk  in  1: clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port adc_valid  in  1: ADC sample present.
REQ-007 SHALL have port adc_sample  in  IN_WIDTH: ADC sample, unsigned.
REQ-008 SHALL have port adc_ready  out  1: FIFO not full.
REQ-009 SHALL have port dt_ready  in  1: classifier accepts a sample this cycle.
REQ-010 SHALL have port dt_valid  out  1: dt_sample valid.
REQ-011 SHALL have port dt_sample  out  IN_WIDTH: sample to classifier.
REQ-012 SHALL have port overflow  out  1: sticky; a sample was dropped.
REQ-013 SHALL have port frame_count  out  16: frames fully delivered.

Function
REQ-014 SHALL push adc_sample into the FIFO when adc_valid and adc_ready are both 1.
REQ-015 SHALL drive adc_ready = !full from registered state, with no same-cycle pop bypass.
REQ-016 SHALL drop the sample and set overflow when adc_valid=1 while full; FIFO contents stay unchanged.
REQ-017 SHALL pop and push in the same cycle when both occur and the FIFO is not full; occupancy is unchanged.
REQ-018 SHALL implement FSM states IDLE, SEND, GAP.
REQ-019 SHALL move IDLE->SEND only when occupancy >= FEATURES and dt_ready=1, so every frame is sent back-to-back with no underrun.
REQ-020 SHALL in SEND hold dt_valid=1 with dt_sample = FIFO head.
REQ-021 SHALL in SEND pop one sample and advance the beat counter on each cycle where dt_ready=1.
REQ-022 SHALL in SEND, when dt_ready=0, hold dt_valid and dt_sample stable and leave the beat counter unchanged.
REQ-023 SHALL move SEND->GAP on the edge that transfers beat FEATURES.
REQ-024 SHALL in GAP drive dt_valid=0 for exactly one cycle, then return to IDLE.
REQ-025 SHALL give a first dt_valid two cycles after the edge that writes the FEATURES-th queued sample, given dt_ready=1 and state IDLE.
REQ-026 SHALL register all outputs except adc_ready.
REQ-027 SHALL increment frame_count modulo 2^16 (65535 -> 0) on the SEND->GAP transition.
REQ-028 SHALL wrap FIFO pointers modulo DEPTH; occupancy counter width is clog2(DEPTH)+1.

Reset
REQ-029 SHALL on reset set state IDLE, flush the FIFO, and clear the beat counter.
REQ-030 SHALL on reset clear dt_valid=0, dt_sample=0, overflow=0, frame_count=0; adc_ready=1 the cycle after reset.
REQ-031 SHALL on reset during SEND abort the partial frame; dt_valid=0 from the next cycle and no count is recorded.

Configuration
REQ-032 SHALL implement frame_count and overflow only when DTREE_FEEDER_STATS_EN is defined.
REQ-033 SHALL, without DTREE_FEEDER_STATS_EN, keep frame_count and overflow as ports tied to 0, with drop behaviour unchanged.

Structure
REQ-034 SHALL take FEATURES/IN_WIDTH defaults and the IDLE/SEND/GAP state enum from shared package dtree_pkg.
REQ-035 SHALL instantiate one sub-module, dtree_feeder_fifo: synchronous FIFO with full, empty and occupancy outputs.

Verification
REQ-036 SHALL test: reset, then push 10,20,30 with dt_ready=1 -> dt_valid beats 10,20,30 on consecutive cycles, one gap cycle, frame_count=1.
REQ-037 SHALL test: push 1..5 -> frame 1,2,3 sent; 4,5 held until a sixth sample arrives, then 4,5,6 sent.
REQ-038 SHALL test: dt_ready low for 3 cycles mid-frame on beat 2 -> dt_sample held at beat-2 value, frame completes intact.
REQ-039 SHALL test: dt_ready=0, push DEPTH+1 samples -> adc_ready=0 after DEPTH, overflow=1, first DEPTH samples later emitted in order.
REQ-040 SHALL test: reset asserted after beat 1 of a frame -> dt_valid=0 next cycle, occupancy 0, frame_count=0.
REQ-041 SHALL test: build without DTREE_FEEDER_STATS_EN, repeat REQ-039 -> overflow and frame_count stay 0.
